// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the GPU main-memory arbiter.
//   arb_state_e : arbiter FSM states
//   arb_cmd_t   : command latched from the winning master at grant time
//   DEFAULT_TIMEOUT_DATA : read data returned when DRAM never answers
package gpu_mem_pkg;

    // Field widths of the latched command; widen these together with the
    // arbiter's ADDR_WIDTH / DATA_WIDTH if a wider DRAM port is ever used.
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } arb_cmd_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per master
//   last_grant : index of the previously granted master
//   win_onehot : one-hot winner (all zero when no request)
//   win_idx    : index of the winner (0 when no request)
// The search starts at last_grant+1 and wraps modulo NUM_MASTERS, so the
// previous winner has the lowest priority.
module rr_pick #(
    parameter  int NUM_MASTERS = 3,
    localparam int IW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          last_grant,
    output logic [NUM_MASTERS-1:0] win_onehot,
    output logic [IW-1:0]          win_idx
);

    logic found;
    int   cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        cand       = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = (int'(last_grant) + i) % NUM_MASTERS;
            if (!found && req[cand]) begin
                found            = 1'b1;
                win_onehot[cand] = 1'b1;
                win_idx          = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing the single DRAM port between GPU masters
// (0 = vertex fetch, 1 = shader core, 2 = framebuffer). One transaction is
// outstanding at a time; reads that never get a response are aborted after
// TIMEOUT cycles and complete with TIMEOUT_DATA and an error pulse.
//   Master side : i_m_req/we/addr/wdata in; o_m_gnt (comb), o_m_done,
//                 o_m_err, o_m_rdata (registered) out
//   DRAM side   : o_dram_req/we/addr/wdata out; i_dram_ready,
//                 i_dram_rvalid, i_dram_rdata in
//   o_busy      : high whenever the FSM is not IDLE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | arbitrating; grant pulses combinationally to the winner
// ISSUE     | command on the DRAM pins, held until i_dram_ready
// WAIT_RESP | read accepted, waiting for i_dram_rvalid or the timeout
module dram_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int                    NUM_MASTERS  = 3,
    parameter int                    ADDR_WIDTH   = CMD_ADDR_W,
    parameter int                    DATA_WIDTH   = CMD_DATA_W,
    parameter int                    TIMEOUT      = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(DEFAULT_TIMEOUT_DATA)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_MASTERS-1:0]                i_m_req,
    input  logic [NUM_MASTERS-1:0]                i_m_we,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] i_m_addr,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] i_m_wdata,
    output logic [NUM_MASTERS-1:0]                o_m_gnt,
    output logic [NUM_MASTERS-1:0]                o_m_done,
    output logic [DATA_WIDTH-1:0]                 o_m_rdata,
    output logic [NUM_MASTERS-1:0]                o_m_err,
    output logic                                  o_dram_req,
    output logic                                  o_dram_we,
    output logic [ADDR_WIDTH-1:0]                 o_dram_addr,
    output logic [DATA_WIDTH-1:0]                 o_dram_wdata,
    input  logic                                  i_dram_ready,
    input  logic                                  i_dram_rvalid,
    input  logic [DATA_WIDTH-1:0]                 i_dram_rdata,
    output logic                                  o_busy
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_e            state_q, state_d;
    arb_cmd_t              cmd_q;
    logic [IW-1:0]         owner_q;
    logic [IW-1:0]         last_grant_q;
    logic [TW-1:0]         timer_q;

    logic [NUM_MASTERS-1:0] win_onehot;
    logic [IW-1:0]          win_idx;
    logic [NUM_MASTERS-1:0] owner_onehot;

    logic gnt_en, load_cmd, done_set, err_set, rdata_load, timer_clr, timer_inc;

    rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
        .req        (i_m_req),
        .last_grant (last_grant_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    assign owner_onehot = NUM_MASTERS'(1) << owner_q;

    always_comb begin
        state_d    = state_q;
        gnt_en     = 1'b0;
        load_cmd   = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        rdata_load = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        o_dram_req = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_en = 1'b1;
                if (|i_m_req) begin
                    load_cmd = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                o_dram_req = 1'b1;
                if (i_dram_ready) begin
                    if (cmd_q.we) begin
                        done_set = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        timer_clr = 1'b1;
                        state_d   = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                // rvalid takes precedence over a timeout in the same cycle
                if (i_dram_rvalid) begin
                    done_set   = 1'b1;
                    rdata_load = 1'b1;
                    state_d    = IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    done_set   = 1'b1;
                    err_set    = 1'b1;
                    rdata_load = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst so the grant is also silent while reset is held.
    assign o_m_gnt      = (gnt_en && !rst) ? win_onehot : '0;
    assign o_busy       = (state_q != IDLE);
    assign o_dram_we    = cmd_q.we;
    assign o_dram_addr  = ADDR_WIDTH'(cmd_q.addr);
    assign o_dram_wdata = DATA_WIDTH'(cmd_q.wdata);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            owner_q      <= '0;
            last_grant_q <= IW'(NUM_MASTERS - 1);
            timer_q      <= '0;
            o_m_done     <= '0;
            o_m_err      <= '0;
            o_m_rdata    <= '0;
        end else begin
            state_q  <= state_d;
            o_m_done <= done_set ? owner_onehot : '0;
            o_m_err  <= err_set ? owner_onehot : '0;
            if (load_cmd) begin
                cmd_q.we     <= i_m_we[win_idx];
                cmd_q.addr   <= CMD_ADDR_W'(i_m_addr[win_idx]);
                cmd_q.wdata  <= CMD_DATA_W'(i_m_wdata[win_idx]);
                owner_q      <= win_idx;
                last_grant_q <= win_idx;
            end
            if (timer_clr) begin
                timer_q <= '0;
            end else if (timer_inc) begin
                timer_q <= timer_q + TW'(1);
            end
            if (rdata_load) begin
                o_m_rdata <= err_set ? TIMEOUT_DATA : i_dram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       i_m_req, i_m_we;
    logic [2:0][31:0] i_m_addr, i_m_wdata;
    logic [2:0]       o_m_gnt, o_m_done, o_m_err;
    logic [31:0]      o_m_rdata;
    logic             o_dram_req, o_dram_we;
    logic [31:0]      o_dram_addr, o_dram_wdata;
    logic             i_dram_ready, i_dram_rvalid;
    logic [31:0]      i_dram_rdata;
    logic             o_busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dram_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_m_req       (i_m_req),
        .i_m_we        (i_m_we),
        .i_m_addr      (i_m_addr),
        .i_m_wdata     (i_m_wdata),
        .o_m_gnt       (o_m_gnt),
        .o_m_done      (o_m_done),
        .o_m_rdata     (o_m_rdata),
        .o_m_err       (o_m_err),
        .o_dram_req    (o_dram_req),
        .o_dram_we     (o_dram_we),
        .o_dram_addr   (o_dram_addr),
        .o_dram_wdata  (o_dram_wdata),
        .i_dram_ready  (i_dram_ready),
        .i_dram_rvalid (i_dram_rvalid),
        .i_dram_rdata  (i_dram_rdata),
        .o_busy        (o_busy)
    );

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  gnt;
        logic        dreq;
        logic [2:0]  done;
        logic        busy;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " gnt"},   64'(o_m_gnt), 64'd0);
        chk({nm, " done"},  64'(o_m_done), 64'd0);
        chk({nm, " err"},   64'(o_m_err), 64'd0);
        chk({nm, " rdata"}, 64'(o_m_rdata), 64'd0);
        chk({nm, " dreq"},  64'(o_dram_req), 64'd0);
        chk({nm, " dwe"},   64'(o_dram_we), 64'd0);
        chk({nm, " daddr"}, 64'(o_dram_addr), 64'd0);
        chk({nm, " dwdat"}, 64'(o_dram_wdata), 64'd0);
        chk({nm, " busy"},  64'(o_busy), 64'd0);
    endtask

    // Master 0 read up to its k-th WAIT_RESP cycle; rvalid optionally on cycle rv_at.
    task automatic read_m0(input int rv_at, input logic [31:0] rv_data, input string nm);
        i_m_req = 3'b001; i_m_we = 3'b000; i_m_addr[0] = 32'h0000_0200;
        sample(); chk({nm, " gnt"}, 64'(o_m_gnt), 64'b001); tick();
        i_m_req = 3'b000; i_dram_ready = 1'b1;
        sample(); chk({nm, " dreq"}, 64'(o_dram_req), 64'd1); tick();
        i_dram_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            i_dram_rvalid = (k == rv_at);
            i_dram_rdata  = (k == rv_at) ? rv_data : 32'h0;
            sample();
            chk({nm, " wait done"}, 64'(o_m_done), 64'd0);
            chk({nm, " wait busy"}, 64'(o_busy), 64'd1);
            tick();
        end
        i_dram_rvalid = 1'b0;
        i_dram_rdata  = 32'h0;
    endtask

    initial begin
        // req, gnt, dreq, done, busy, addr (checked only when dreq)
        tbl[0]  = '{3'b111, 3'b001, 1'b0, 3'b000, 1'b0, 32'h0};
        tbl[1]  = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 32'h1000};
        tbl[2]  = '{3'b111, 3'b010, 1'b0, 3'b001, 1'b0, 32'h0};
        tbl[3]  = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 32'h2000};
        tbl[4]  = '{3'b111, 3'b100, 1'b0, 3'b010, 1'b0, 32'h0};
        tbl[5]  = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 32'h3000};
        tbl[6]  = '{3'b111, 3'b001, 1'b0, 3'b100, 1'b0, 32'h0};
        tbl[7]  = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 32'h1000};
        tbl[8]  = '{3'b111, 3'b010, 1'b0, 3'b001, 1'b0, 32'h0};
        tbl[9]  = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 32'h2000};
        tbl[10] = '{3'b111, 3'b100, 1'b0, 3'b010, 1'b0, 32'h0};
        tbl[11] = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 32'h3000};
        tbl[12] = '{3'b000, 3'b000, 1'b0, 3'b100, 1'b0, 32'h0};
        tbl[13] = '{3'b101, 3'b001, 1'b0, 3'b000, 1'b0, 32'h0};
        tbl[14] = '{3'b100, 3'b000, 1'b1, 3'b000, 1'b1, 32'h1000};
        tbl[15] = '{3'b110, 3'b010, 1'b0, 3'b001, 1'b0, 32'h0};
        tbl[16] = '{3'b100, 3'b000, 1'b1, 3'b000, 1'b1, 32'h2000};
        tbl[17] = '{3'b100, 3'b100, 1'b0, 3'b010, 1'b0, 32'h0};
        tbl[18] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 32'h3000};
        tbl[19] = '{3'b000, 3'b000, 1'b0, 3'b100, 1'b0, 32'h0};

        rst = 1'b1;
        i_m_req = '0; i_m_we = '0; i_m_addr = '0; i_m_wdata = '0;
        i_dram_ready = 1'b0; i_dram_rvalid = 1'b0; i_dram_rdata = '0;
        tick(); tick();

        // Reset: requests present but everything stays quiet
        i_m_req = 3'b111;
        sample(); chk_all_zero("reset");
        tick();
        i_m_req = 3'b000; rst = 1'b0;
        tick();

        // Contention and rotation, all writes, DRAM always ready
        for (int m = 0; m < 3; m++) begin
            i_m_addr[m]  = 32'(m + 1) << 12;
            i_m_wdata[m] = 32'hA0 + 32'(m);
        end
        i_m_we = 3'b111;
        i_dram_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            i_m_req = tbl[i].req;
            sample();
            chk($sformatf("tbl%0d gnt", i),  64'(o_m_gnt), 64'(tbl[i].gnt));
            chk($sformatf("tbl%0d dreq", i), 64'(o_dram_req), 64'(tbl[i].dreq));
            chk($sformatf("tbl%0d done", i), 64'(o_m_done), 64'(tbl[i].done));
            chk($sformatf("tbl%0d err", i),  64'(o_m_err), 64'd0);
            chk($sformatf("tbl%0d busy", i), 64'(o_busy), 64'(tbl[i].busy));
            if (tbl[i].dreq)
                chk($sformatf("tbl%0d addr", i), 64'(o_dram_addr), 64'(tbl[i].addr));
            tick();
        end
        i_m_req = 3'b000; i_dram_ready = 1'b0;

        // Single read by master 1, rvalid three cycles after acceptance
        i_m_req = 3'b010; i_m_we = 3'b000; i_m_addr[1] = 32'h100;
        sample(); chk("rd gnt", 64'(o_m_gnt), 64'b010); chk("rd dreq T", 64'(o_dram_req), 64'd0); tick();
        i_m_req = 3'b000; i_dram_ready = 1'b1;
        sample();
        chk("rd dreq T+1", 64'(o_dram_req), 64'd1);
        chk("rd addr", 64'(o_dram_addr), 64'h100);
        chk("rd we", 64'(o_dram_we), 64'd0);
        tick();
        i_dram_ready = 1'b0;
        sample(); chk("rd wait dreq", 64'(o_dram_req), 64'd0); chk("rd wait busy", 64'(o_busy), 64'd1); tick();
        sample(); chk("rd wait done", 64'(o_m_done), 64'd0); tick();
        i_dram_rvalid = 1'b1; i_dram_rdata = 32'h1234_5678;
        sample(); chk("rd rv done", 64'(o_m_done), 64'd0); tick();
        i_dram_rvalid = 1'b0; i_dram_rdata = 32'h0;
        sample();
        chk("rd done", 64'(o_m_done), 64'b010);
        chk("rd rdata", 64'(o_m_rdata), 64'h1234_5678);
        chk("rd err", 64'(o_m_err), 64'd0);
        chk("rd busy", 64'(o_busy), 64'd0);
        tick();
        sample(); chk("rd done pulse", 64'(o_m_done), 64'd0); chk("rd rdata hold", 64'(o_m_rdata), 64'h1234_5678); tick();

        // Write by master 2 with DRAM stalled for five cycles
        i_m_req = 3'b100; i_m_we = 3'b100; i_m_addr[2] = 32'h40; i_m_wdata[2] = 32'hAA;
        sample(); chk("ws gnt", 64'(o_m_gnt), 64'b100); tick();
        i_m_req = 3'b000;
        for (int k = 0; k < 6; k++) begin
            i_dram_ready = (k == 5);
            sample();
            chk($sformatf("ws%0d dreq", k),  64'(o_dram_req), 64'd1);
            chk($sformatf("ws%0d addr", k),  64'(o_dram_addr), 64'h40);
            chk($sformatf("ws%0d wdata", k), 64'(o_dram_wdata), 64'hAA);
            chk($sformatf("ws%0d we", k),    64'(o_dram_we), 64'd1);
            chk($sformatf("ws%0d done", k),  64'(o_m_done), 64'd0);
            tick();
        end
        i_dram_ready = 1'b0;
        sample();
        chk("ws done", 64'(o_m_done), 64'b100);
        chk("ws dreq off", 64'(o_dram_req), 64'd0);
        chk("ws rdata hold", 64'(o_m_rdata), 64'h1234_5678);
        tick();

        // Timeout with no response
        read_m0(0, 32'h0, "to");
        sample();
        chk("to done", 64'(o_m_done), 64'b001);
        chk("to err", 64'(o_m_err), 64'b001);
        chk("to rdata", 64'(o_m_rdata), 64'hDEAD_BEEF);
        chk("to busy", 64'(o_busy), 64'd0);
        tick();
        sample(); chk("to done pulse", 64'(o_m_done), 64'd0); chk("to err pulse", 64'(o_m_err), 64'd0); tick();

        // Response arriving in the final WAIT_RESP cycle beats the timeout
        read_m0(8, 32'h55, "late");
        sample();
        chk("late done", 64'(o_m_done), 64'b001);
        chk("late err", 64'(o_m_err), 64'd0);
        chk("late rdata", 64'(o_m_rdata), 64'h55);
        tick();

        // Reset during WAIT_RESP (master 0 was last granted)
        i_m_req = 3'b001; i_m_we = 3'b000;
        sample(); chk("mr gnt", 64'(o_m_gnt), 64'b001); tick();
        i_m_req = 3'b000; i_dram_ready = 1'b1;
        tick();
        i_dram_ready = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1 chk_all_zero("mid rst");
        i_dram_rvalid = 1'b1; i_dram_rdata = 32'h99;
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk($sformatf("mr%0d done", k), 64'(o_m_done), 64'd0);
            chk($sformatf("mr%0d busy", k), 64'(o_busy), 64'd0);
            tick();
        end
        i_dram_rvalid = 1'b0;
        i_m_req = 3'b101;
        sample(); chk("mr prio", 64'(o_m_gnt), 64'b001); tick();
        i_m_req = 3'b000;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Round-robin arbiter that shares the single main-memory (DRAM) port between the GPU memory masters: 0 = vertex fetch, 1 = shader core, 2 = framebuffer.
- One transaction is outstanding at a time: grant, issue, then wait for the response.
- Includes a read-response timeout, so a dead DRAM cannot hang the pipeline.
- Sits between the masters and the top-level o_dram_* pins.

Parameters:
- NUM_MASTERS, 3, number of requesters (≥2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT, 255, maximum WAIT_RESP cycles before a read is aborted (≥1).
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on a timeout.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- i_m_req  in  NUM_MASTERS  per-master request; held until the matching o_m_gnt.
- i_m_we  in  NUM_MASTERS  per-master write enable (1 = write, 0 = read).
- i_m_addr  in  NUM_MASTERS x ADDR_WIDTH  per-master address.
- i_m_wdata  in  NUM_MASTERS x DATA_WIDTH  per-master write data.
- o_m_gnt  out  NUM_MASTERS  one-hot, one-cycle pulse; the request is captured this cycle.
- o_m_done  out  NUM_MASTERS  one-hot, one-cycle completion pulse.
- o_m_rdata  out  DATA_WIDTH  read data, shared by all masters; valid with o_m_done on reads.
- o_m_err  out  NUM_MASTERS  one-cycle pulse, coincident with o_m_done, on a timeout.
- o_dram_req  out  1  DRAM command valid.
- o_dram_we  out  1  DRAM write enable.
- o_dram_addr  out  ADDR_WIDTH  DRAM address.
- o_dram_wdata  out  DATA_WIDTH  DRAM write data.
- i_dram_ready  in  1  DRAM accepts the command this cycle (when o_dram_req=1).
- i_dram_rvalid  in  1  DRAM read data valid.
- i_dram_rdata  in  DATA_WIDTH  DRAM read data.
- o_busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, last_grant=NUM_MASTERS-1 (so master 0 has first priority), timer=0.
  - All outputs 0, and the latched command registers are 0.
  - An asserted reset mid-transaction abandons the transaction; no o_m_done is issued.
- IDLE:
  - If any i_m_req is set, the winner is the first requester searching last_grant+1, last_grant+2, … modulo NUM_MASTERS.
  - o_m_gnt[winner] is driven combinationally in the same cycle.
  - At the clock edge: latch winner's we/addr/wdata and owner; last_grant←winner; state←ISSUE.
  - No requests: remain in IDLE.
- ISSUE:
  - o_dram_req=1; o_dram_we/addr/wdata come from the latched registers and stay stable until accepted.
  - Without i_dram_ready: hold, with no stall limit.
  - i_dram_ready with a write: next cycle o_m_done[owner]=1 and state=IDLE.
  - i_dram_ready with a read: state←WAIT_RESP, timer←0.
- WAIT_RESP:
  - o_dram_req=0.
  - On i_dram_rvalid: o_m_rdata←i_dram_rdata and o_m_done[owner] in the next cycle; state←IDLE.
  - Otherwise timer increments; if timer==TIMEOUT-1 and no rvalid: o_m_rdata←TIMEOUT_DATA with o_m_done[owner] and o_m_err[owner] next cycle; state←IDLE.
  - rvalid in the timeout cycle: rvalid wins and o_m_err stays 0.
- Latency:
  - Grant in cycle T → o_dram_req first high at T+1.
  - Write accepted at cycle A → done at A+1.
  - rvalid at cycle R → done/rdata at R+1.
  - A new grant is possible in the same cycle done is asserted, since state=IDLE then.
- Outputs:
  - o_m_done, o_m_err and o_m_rdata are registered.
  - o_m_rdata holds its last value between reads.
  - o_m_gnt is 0 outside IDLE.
- Stray inputs:
  - i_dram_rvalid in IDLE or ISSUE is ignored.
  - i_dram_ready is ignored outside ISSUE.
- Fairness:
  - A master that keeps requesting is granted at most once per NUM_MASTERS grants while others are requesting.
  - A request withdrawn before its grant is simply dropped from arbitration.

Decomposition:
- Package gpu_mem_pkg:
  - arb_state_e enum {IDLE, ISSUE, WAIT_RESP};
  - default TIMEOUT_DATA constant;
  - typedef for the latched command struct {we, addr, wdata}.
- One sub-module, rr_pick: combinational; inputs are the request vector and last_grant; outputs are a one-hot winner and its index. Parameterised by NUM_MASTERS.

Test Plan:
- Single read: master 1 reads addr 0x100; DRAM ready at once, rvalid 3 cycles later with 0x1234_5678.
  - Required: gnt[1] at T, dram_req at T+1, done[1] with rdata 0x1234_5678 one cycle after rvalid, err=0.
- Contention: all three masters request continuously (writes, ready always 1).
  - Required: grant order 0,1,2,0,1,2; each done one cycle after acceptance.
- Write stall: master 2 writes 0xAA at 0x40; i_dram_ready held low for 5 cycles.
  - Required: o_dram_req/addr/wdata stable for 6 cycles; done[2] one cycle after ready.
- Timeout, no response (TIMEOUT=8): master 0 reads and rvalid never arrives.
  - Required: after 8 WAIT_RESP cycles, done[0] and err[0] pulse together with rdata 0xDEAD_BEEF; o_busy drops.
- Timeout, late response (TIMEOUT=8): rvalid with 0x55 arrives on the 8th WAIT_RESP cycle.
  - Required: done[0] with rdata 0x55, err=0.
- Reset mid-operation: assert rst during WAIT_RESP.
  - Required: all outputs 0 immediately and no done is ever issued.
  - Required after release: master 0 has first priority when 0 and 2 request simultaneously.
